// File: rtl/enum_seq_monitor_pkg.sv
// enum_seq_pkg: token and monitor state types shared by the sequence monitor.
package enum_seq_pkg;
    typedef enum logic [1:0] {ts0, ts1, ts2, ts3} states_t;
    typedef enum logic [1:0] {MON_IDLE = 2'd0, MON_RUN = 2'd1, MON_ERR = 2'd2} mon_state_t;
    function automatic states_t next_state(states_t s);
        return (s == ts0) ? ts1 : (s == ts1) ? ts2 : ts0;
    endfunction
endpackage

// File: rtl/enum_seq_sat_cnt.sv
// enum_seq_sat_cnt: saturating up-counter with synchronous clear.
module enum_seq_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/enum_seq_monitor.sv
// enum_seq_monitor: checks the ts0->ts1->ts2 token cycle and counts legal tokens.
// Define ENUM_SEQ_MONITOR_ASSERT_EN to compile in internal consistency assertions.
module enum_seq_monitor
    import enum_seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  states_t          in_state,
    input  logic             clear,
    output mon_state_t       mon_state,
    output logic             err,
    output states_t          err_state,
    output logic [CNT_W-1:0] cnt_ts0,
    output logic [CNT_W-1:0] cnt_ts1,
    output logic [CNT_W-1:0] cnt_ts2,
    output logic [CNT_W-1:0] err_cnt
);
    mon_state_t state_d;
    states_t    prev;
    logic       acc, sync, legal, illegal, hit;
    assign in_ready = rst_n && !clear && mon_state != MON_ERR;
    assign acc      = in_valid && in_ready;
    assign sync     = acc && mon_state == MON_IDLE && in_state == ts0;
    assign legal    = acc && mon_state == MON_RUN && in_state == next_state(prev);
    assign illegal  = acc && mon_state == MON_RUN && !legal;
    assign hit      = sync || legal;
    always_comb begin
        state_d = mon_state;
        state_d = clear ? MON_IDLE : sync ? MON_RUN : illegal ? MON_ERR : mon_state;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mon_state <= MON_IDLE;
            prev      <= ts0;
            err       <= 1'b0;
            err_state <= ts0;
        end else begin
            mon_state <= state_d;
            if (hit) prev <= in_state;
            if (clear) begin
                err       <= 1'b0;
                err_state <= ts0;
            end else if (illegal) begin
                err       <= 1'b1;
                err_state <= in_state;
            end
        end
    enum_seq_sat_cnt #(.CNT_W(CNT_W)) u_cnt0 (.clk(clk), .rst_n(rst_n), .inc(hit && in_state == ts0), .clr(clear), .cnt(cnt_ts0));
    enum_seq_sat_cnt #(.CNT_W(CNT_W)) u_cnt1 (.clk(clk), .rst_n(rst_n), .inc(hit && in_state == ts1), .clr(clear), .cnt(cnt_ts1));
    enum_seq_sat_cnt #(.CNT_W(CNT_W)) u_cnt2 (.clk(clk), .rst_n(rst_n), .inc(hit && in_state == ts2), .clr(clear), .cnt(cnt_ts2));
    enum_seq_sat_cnt #(.CNT_W(CNT_W)) u_cnte (.clk(clk), .rst_n(rst_n), .inc(illegal), .clr(clear), .cnt(err_cnt));
`ifdef ENUM_SEQ_MONITOR_ASSERT_EN
    // Previous-cycle snapshot for the monotonic counter check; void after a clear.
    logic [4*CNT_W-1:0] last_cnt;
    logic               last_ok;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            last_cnt <= '0;
            last_ok  <= 1'b0;
        end else begin
            last_cnt <= {cnt_ts0, cnt_ts1, cnt_ts2, err_cnt};
            last_ok  <= !clear;
        end
    always_ff @(posedge clk)
        if (rst_n) begin
            assert (mon_state != 2'd3);
            assert (err == (mon_state == MON_ERR));
            assert (!(mon_state == MON_ERR && in_ready));
            assert (prev != ts3);
            if (last_ok) begin
                assert (cnt_ts0 >= last_cnt[4*CNT_W-1:3*CNT_W]);
                assert (cnt_ts1 >= last_cnt[3*CNT_W-1:2*CNT_W]);
                assert (cnt_ts2 >= last_cnt[2*CNT_W-1:CNT_W]);
                assert (err_cnt >= last_cnt[CNT_W-1:0]);
            end
        end
`endif
endmodule

// File: doc/enum_seq_monitor.md
# enum_seq_monitor

Downstream consumer for the two-bit `states_t` sequence produced by the enum state-machine stage (ts0 → ts1 → ts2 → ts0). It accepts one state token per valid/ready handshake, checks every transition against the legal cycle, and counts accepted occurrences of each legal state. On the first illegal token it stops accepting input until software clears it. The block is the synthesizable checker that the svtypes enum tests use, and its own controller is also an enum-typed FSM.

## Interface
- `CNT_W`, default 8: width of every occurrence and error counter; legal range 2..16.
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: upstream token valid.
- `in_ready` output, 1 bit: monitor can accept a token this cycle.
- `in_state` input, `states_t` (2 bits): the state token.
- `clear` input, 1 bit: synchronous restart pulse.
- `mon_state` output, `mon_state_t` (2 bits): current monitor FSM state.
- `err` output, 1 bit: sticky illegal-transition flag.
- `err_state` output, `states_t`: the token that caused `err`.
- `cnt_ts0`, `cnt_ts1`, `cnt_ts2` outputs, `CNT_W` bits each: accepted legal occurrences of ts0, ts1 and ts2.
- `err_cnt` output, `CNT_W` bits: number of error entries since reset or clear.

## Operation
- Accept condition: a token is accepted when `in_valid && in_ready`.
- `mon_state_t` has three states:
  - MON_IDLE = 2'd0
  - MON_RUN = 2'd1
  - MON_ERR = 2'd2
  - 2'd3 is unused and unreachable.
- MON_IDLE:
  - `in_ready` = 1.
  - An accepted ts0 increments `cnt_ts0`, loads the internal `prev` register with ts0, and moves to MON_RUN.
  - Accepted ts1, ts2 or ts3 tokens are dropped while the block waits to synchronise. They do not set `err` and do not change any counter.
- MON_RUN:
  - `in_ready` = 1.
  - An accepted token equal to `next(prev)` is legal. `next` maps ts0→ts1, ts1→ts2, ts2→ts0.
  - A legal token increments its counter, updates `prev`, and the block stays in MON_RUN.
  - Any other token is illegal, including a repeat of `prev` and any ts3. An illegal token sets `err`, loads `err_state`, increments `err_cnt`, and moves to MON_ERR. No occurrence counter changes.
- MON_ERR:
  - `in_ready` = 0.
  - The block holds all outputs until `clear`.
- `clear`, from any state:
  - Next state is MON_IDLE.
  - `err` ← 0 and `err_state` ← ts0.
  - All four counters ← 0.
  - `clear` overrides a simultaneous handshake: `in_ready` is forced to 0 in any cycle where `clear` = 1, so no token is lost ambiguously.
- Counters saturate at 2^CNT_W−1 and never wrap.
- `prev` is internal, resets to ts0, and is meaningful only in MON_RUN.

## Timing
- `in_ready` is combinational from `mon_state`, `clear` and `rst_n`, with no dependency on `in_valid`.
- `in_ready` = 0 while `rst_n` = 0.
- All other outputs are registered. The effect of an accepted token appears on the outputs in the cycle after the accepting edge. Throughput is one token per cycle in MON_IDLE and MON_RUN.
- Reset values:
  - `mon_state` = MON_IDLE
  - `err` = 0
  - `err_state` = ts0
  - all counters = 0
  - `prev` = ts0
- Reset asserted mid-sequence returns the block to the reset values immediately, without waiting for a clock edge. The first token after reset release must be ts0 for the block to leave MON_IDLE.
- An illegal token is accepted, so `in_ready` was 1 in that cycle. `in_ready` falls in the cycle after it.

## Configuration
- Macro `ENUM_SEQ_MONITOR_ASSERT_EN`.
- When defined, the block compiles in immediate assertions checked every cycle (reset-qualified):
  - `mon_state != 2'd3`
  - `err == (mon_state == MON_ERR)`
  - `in_ready == 0` in MON_ERR
  - no counter decreases except on `clear`
  - `prev != ts3`
- When not defined, none of these assertions are present, and functional behaviour is identical.

## Structure
- Package `enum_seq_pkg` holds:
  - `typedef enum logic [1:0] states_t {ts0, ts1, ts2, ts3}`
  - `typedef enum logic [1:0] mon_state_t` with the encodings given under Operation
  - function `next_state(states_t)`
- Sub-module `enum_seq_sat_cnt`, parameterised by `CNT_W`, with inputs `inc` and `clr`. It is a saturating counter instantiated four times.

## Test plan
- Reset, then tokens ts0,ts1,ts2,ts0 back-to-back with `in_valid` = 1 → `mon_state` = MON_RUN; counts 2/1/1; `err` = 0; `in_ready` = 1 throughout.
- From reset, tokens ts2,ts1,ts0,ts1 → first two dropped; counts 1/1/0; `err` = 0.
- In MON_RUN with `prev` = ts1, present ts3 → next cycle `err` = 1, `err_state` = ts3, `err_cnt` = 1, MON_ERR, `in_ready` = 0. A further `in_valid` is not accepted.
- In MON_ERR, assert `clear` with `in_valid` = 1 carrying ts0 → `in_ready` = 0 that cycle; next cycle MON_IDLE, all counters 0, `err` = 0.
- With `CNT_W` = 2, feed 5 full cycles ts0,ts1,ts2 → each count holds at 3; `err` = 0.
- Assert `rst_n` low mid-stream between clock edges → outputs reach reset values before the next edge.
